// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the adder front end: field widths, special-class
// encoding, the stage-1 register record and an operand unpack helper.
package fp32_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int SIG_W = 25;
   localparam int BIAS  = 127;

   localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
   localparam logic [4:0]       DIFF_SAT = 5'd25;

   typedef enum logic [1:0] {
      SP_NORM = 2'b00,
      SP_ZERO = 2'b01,
      SP_INF  = 2'b10,
      SP_NAN  = 2'b11
   } sp_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
      logic [MAN_W:0]   sig;
   } fp_unp_t;

   // Ordered, classified operand pair held between the two stages.
   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W:0]   big_sig;
      logic [MAN_W:0]   small_sig;
      logic [4:0]       diff;
      logic             eff_sub;
      sp_e              special;
   } s1_t;

   // Denormals are flushed: exp==0 yields a zero significand regardless of man.
   function automatic fp_unp_t fp_unpack(input logic [31:0] v, input logic flip_sign);
      fp_unp_t u;
      u.sign    = v[31] ^ flip_sign;
      u.exp     = v[30:23];
      u.man     = v[22:0];
      u.is_zero = (u.exp == '0);
      u.is_inf  = (u.exp == EXP_MAX) && (u.man == '0);
      u.is_nan  = (u.exp == EXP_MAX) && (u.man != '0);
      u.sig     = u.is_zero ? '0 : {1'b1, u.man};
      return u;
   endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand/result stream bundle for fp_add_align. The slave view is the
// adder itself; the master view is whatever feeds operands and drains results.
interface fp_add_align_if;
   import fp32_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [EXP_W-1:0] out_exp;
   logic [SIG_W-1:0] out_sig;
   logic             out_sticky;
   logic [1:0]       out_special;

   modport slave (
      input  in_valid, op_a, op_b, sub, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sig, out_sticky, out_special
   );

   modport master (
      output in_valid, op_a, op_b, sub, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sig, out_sticky, out_special
   );

endinterface

// File: rtl/fp_align_shift.sv
// Combinational significand aligner: right-shifts the smaller significand by
// the exponent difference and reports whether any set bit fell off the end.
module fp_align_shift
   import fp32_pkg::*;
(
   input  logic [MAN_W:0] sig_in,
   input  logic [4:0]     shamt,
   output logic [MAN_W:0] sig_out,
   output logic           sticky
);

   localparam logic [4:0] SIG_LEN = 5'(MAN_W + 1);

   logic [MAN_W:0] mask;

   // Shift amounts of 24 and 25 push the whole significand out.
   always_comb begin
      sig_out = '0;
      sticky  = 1'b0;
      mask    = '0;
      if (shamt >= SIG_LEN) begin
         sticky = |sig_in;
      end else begin
         sig_out = sig_in >> shamt;
         mask    = ~({(MAN_W+1){1'b1}} << shamt);
         sticky  = |(sig_in & mask);
      end
   end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage FP32 adder front end. S1 unpacks, classifies and orders the
// operands; S2 aligns the smaller significand and adds or subtracts it.
// Each stage has its own valid flag so bubbles collapse under backpressure.
module fp_add_align
   import fp32_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic         clk,
   input  logic         rst,
   fp_add_align_if.slave bus
);

   logic             ready1, ready2, load1, load2;
   logic             v1_d, v1_q, v2_d, v2_q;
   s1_t              s1_d, s1_q;

   fp_unp_t          a_u, b_u;
   logic             a_big, eff_sub;
   logic [EXP_W-1:0] exp_diff;

   logic [MAN_W:0]   aligned;
   logic             shift_sticky;
   logic [MAN_W+1:0] sum;

   logic             out_sign_d, out_sign_q;
   logic [EXP_W-1:0] out_exp_d, out_exp_q;
   logic [MAN_W+1:0] out_sig_d, out_sig_q;
   logic             out_sticky_d, out_sticky_q;
   sp_e              out_special_d, out_special_q;

   assign ready2 = !v2_q || bus.out_ready;
   assign ready1 = !v1_q || ready2;
   assign load1  = bus.in_valid && ready1;
   assign load2  = v1_q && ready2;

   assign bus.in_ready    = ready1;
   assign bus.out_valid   = v2_q;
   assign bus.out_sign    = out_sign_q;
   assign bus.out_exp     = out_exp_q;
   assign bus.out_sig     = out_sig_q;
   assign bus.out_sticky  = out_sticky_q;
   assign bus.out_special = out_special_q;

   // S1: unpack, pick the larger magnitude (A wins ties), classify specials.
   always_comb begin
      a_u      = fp_unpack(bus.op_a, 1'b0);
      b_u      = fp_unpack(bus.op_b, bus.sub);
      eff_sub  = a_u.sign ^ b_u.sign;
      a_big    = {a_u.exp, a_u.man} >= {b_u.exp, b_u.man};
      exp_diff = a_big ? (a_u.exp - b_u.exp) : (b_u.exp - a_u.exp);

      v1_d = ready1 ? bus.in_valid : v1_q;
      s1_d = s1_q;
      if (load1) begin
         s1_d.sign      = a_big ? a_u.sign : b_u.sign;
         s1_d.exp       = a_big ? a_u.exp  : b_u.exp;
         s1_d.big_sig   = a_big ? a_u.sig  : b_u.sig;
         s1_d.small_sig = a_big ? b_u.sig  : a_u.sig;
         s1_d.diff      = (exp_diff > EXP_W'(DIFF_SAT)) ? DIFF_SAT : exp_diff[4:0];
         s1_d.eff_sub   = eff_sub;
         s1_d.special   = SP_NORM;
         if (a_u.is_nan || b_u.is_nan || (a_u.is_inf && b_u.is_inf && eff_sub)) begin
            s1_d.special = SP_NAN;
            s1_d.sign    = 1'b0;
         end else if (a_u.is_inf) begin
            s1_d.special = SP_INF;
            s1_d.sign    = a_u.sign;
         end else if (b_u.is_inf) begin
            s1_d.special = SP_INF;
            s1_d.sign    = b_u.sign;
         end else if (a_u.is_zero && b_u.is_zero) begin
            s1_d.special = SP_ZERO;
            s1_d.sign    = a_u.sign & b_u.sign;
         end
      end
   end

   fp_align_shift u_align_shift (
      .sig_in  (s1_q.small_sig),
      .shamt   (s1_q.diff),
      .sig_out (aligned),
      .sticky  (shift_sticky)
   );

   // S2: add/subtract the aligned significands; big >= aligned so no borrow out.
   always_comb begin
      sum = s1_q.eff_sub ? ({1'b0, s1_q.big_sig} - {1'b0, aligned})
                         : ({1'b0, s1_q.big_sig} + {1'b0, aligned});

      v2_d          = ready2 ? v1_q : v2_q;
      out_sign_d    = out_sign_q;
      out_exp_d     = out_exp_q;
      out_sig_d     = out_sig_q;
      out_sticky_d  = out_sticky_q;
      out_special_d = out_special_q;
      if (load2) begin
         out_exp_d     = s1_q.exp;
         out_special_d = s1_q.special;
         if (s1_q.special != SP_NORM) begin
            out_sign_d   = s1_q.sign;
            out_sig_d    = '0;
            out_sticky_d = 1'b0;
         end else begin
            out_sign_d   = (s1_q.eff_sub && (sum == '0)) ? 1'b0 : s1_q.sign;
            out_sig_d    = sum;
            out_sticky_d = shift_sticky;
         end
      end
   end

   // Pipeline registers; reset empties both stages and clears the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q          <= 1'b0;
         v2_q          <= 1'b0;
         s1_q          <= '0;
         out_sign_q    <= 1'b0;
         out_exp_q     <= '0;
         out_sig_q     <= '0;
         out_sticky_q  <= 1'b0;
         out_special_q <= SP_NORM;
      end else begin
         v1_q          <= v1_d;
         v2_q          <= v2_d;
         s1_q          <= s1_d;
         out_sign_q    <= out_sign_d;
         out_exp_q     <= out_exp_d;
         out_sig_q     <= out_sig_d;
         out_sticky_q  <= out_sticky_d;
         out_special_q <= out_special_d;
      end
   end

endmodule

// File: tb/tb_fp_add_align.sv
// Directed bench for fp_add_align: a table of single operations with
// hand-computed results, then backpressure and mid-stream reset sequences.
module tb_fp_add_align;

   logic clk;
   logic rst;
   int   n_run;
   int   n_fail;

   fp_add_align_if bus ();

   fp_add_align dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic        e_sign;
      logic [7:0]  e_exp;
      logic [24:0] e_sig;
      logic        e_sticky;
      logic [1:0]  e_special;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input logic sg, input logic [7:0] e, input logic [24:0] sig,
                                input logic st, input logic [1:0] sp);
      vec_t v;
      v.a = a; v.b = b; v.sub = s;
      v.e_sign = sg; v.e_exp = e; v.e_sig = sig; v.e_sticky = st; v.e_special = sp;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_run++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   waited;
      int   lat;
      v = vecs[idx];
      @(negedge clk);
      bus.op_a      = v.a;
      bus.op_b      = v.b;
      bus.sub       = v.sub;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      waited = 0;
      while (!bus.in_ready && waited < 10) begin
         @(negedge clk);
         #1;
         waited++;
      end
      chk($sformatf("v%0d.in_ready", idx), {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d.latency", idx), lat, 32'd2);
      chk($sformatf("v%0d.sign", idx), {31'd0, bus.out_sign}, {31'd0, v.e_sign});
      chk($sformatf("v%0d.exp", idx), {24'd0, bus.out_exp}, {24'd0, v.e_exp});
      chk($sformatf("v%0d.sig", idx), {7'd0, bus.out_sig}, {7'd0, v.e_sig});
      chk($sformatf("v%0d.sticky", idx), {31'd0, bus.out_sticky}, {31'd0, v.e_sticky});
      chk($sformatf("v%0d.special", idx), {30'd0, bus.out_special}, {30'd0, v.e_special});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bp_a [4];
      logic [31:0] bp_b [4];
      logic        bp_s [4];
      logic [24:0] bp_sig [4];
      logic [7:0]  bp_exp [4];
      int          sent;
      int          rcv;
      logic        acc;

      n_run  = 0;
      n_fail = 0;

      //            a             b             sub  sign  exp    sig          sticky special
      vecs[0]  = mkv(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 25'h1000000, 1'b0, 2'b00);
      vecs[1]  = mkv(32'h3FC00000, 32'h40400000, 1'b1, 1'b1, 8'h80, 25'h0600000, 1'b0, 2'b00);
      vecs[2]  = mkv(32'h3F800000, 32'h30800000, 1'b0, 1'b0, 8'h7F, 25'h0800000, 1'b1, 2'b00);
      vecs[3]  = mkv(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 8'h7F, 25'h0000000, 1'b0, 2'b00);
      vecs[4]  = mkv(32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 8'hFF, 25'h0000000, 1'b0, 2'b11);
      vecs[5]  = mkv(32'hFF800000, 32'h3F800000, 1'b0, 1'b1, 8'hFF, 25'h0000000, 1'b0, 2'b10);
      vecs[6]  = mkv(32'h3F800000, 32'h00000000, 1'b0, 1'b0, 8'h7F, 25'h0800000, 1'b0, 2'b00);
      vecs[7]  = mkv(32'h00000000, 32'h80000000, 1'b0, 1'b0, 8'h00, 25'h0000000, 1'b0, 2'b01);
      vecs[8]  = mkv(32'h80000000, 32'h00000000, 1'b1, 1'b1, 8'h00, 25'h0000000, 1'b0, 2'b01);
      vecs[9]  = mkv(32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 8'hFF, 25'h0000000, 1'b0, 2'b11);
      vecs[10] = mkv(32'h3F800000, 32'h7F800000, 1'b1, 1'b1, 8'hFF, 25'h0000000, 1'b0, 2'b10);
      vecs[11] = mkv(32'h00400000, 32'h3F800000, 1'b0, 1'b0, 8'h7F, 25'h0800000, 1'b0, 2'b00);
      vecs[12] = mkv(32'h00400000, 32'h00000001, 1'b0, 1'b0, 8'h00, 25'h0000000, 1'b0, 2'b01);
      vecs[13] = mkv(32'hBF800000, 32'hBF800000, 1'b1, 1'b0, 8'h7F, 25'h0000000, 1'b0, 2'b00);
      vecs[14] = mkv(32'h3F800000, 32'hC0000000, 1'b0, 1'b1, 8'h80, 25'h0400000, 1'b0, 2'b00);
      vecs[15] = mkv(32'h3F800000, 32'h3E800001, 1'b0, 1'b0, 8'h7F, 25'h0A00000, 1'b1, 2'b00);
      vecs[16] = mkv(32'h3F800000, 32'h33800001, 1'b0, 1'b0, 8'h7F, 25'h0800000, 1'b1, 2'b00);
      vecs[17] = mkv(32'h3F800000, 32'h34000000, 1'b0, 1'b0, 8'h7F, 25'h0800001, 1'b0, 2'b00);
      vecs[18] = mkv(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 8'hFE, 25'h1FFFFFE, 1'b0, 2'b00);

      bp_a[0] = 32'h3F800000; bp_b[0] = 32'h3F800000; bp_s[0] = 1'b0; bp_exp[0] = 8'h7F; bp_sig[0] = 25'h1000000;
      bp_a[1] = 32'h3FC00000; bp_b[1] = 32'h40400000; bp_s[1] = 1'b1; bp_exp[1] = 8'h80; bp_sig[1] = 25'h0600000;
      bp_a[2] = 32'h40000000; bp_b[2] = 32'h3F800000; bp_s[2] = 1'b1; bp_exp[2] = 8'h80; bp_sig[2] = 25'h0400000;
      bp_a[3] = 32'h3F800000; bp_b[3] = 32'h34000000; bp_s[3] = 1'b0; bp_exp[3] = 8'h7F; bp_sig[3] = 25'h0800001;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("reset.out_sig", {7'd0, bus.out_sig}, 32'd0);
      chk("reset.out_exp", {24'd0, bus.out_exp}, 32'd0);
      chk("reset.out_special", {30'd0, bus.out_special}, 32'd0);

      for (int i = 0; i < NV; i++) begin
         run_vec(i);
      end

      // Backpressure: four back-to-back operations, result side stalled 3 cycles.
      sent = 0;
      rcv  = 0;
      for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
         @(negedge clk);
         bus.out_ready = (cyc >= 3);
         if (sent < 4) begin
            bus.op_a     = bp_a[sent];
            bus.op_b     = bp_b[sent];
            bus.sub      = bp_s[sent];
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.out_valid) begin
            chk($sformatf("bp%0d.c%0d.sig", rcv, cyc), {7'd0, bus.out_sig}, {7'd0, bp_sig[rcv]});
            chk($sformatf("bp%0d.c%0d.exp", rcv, cyc), {24'd0, bus.out_exp}, {24'd0, bp_exp[rcv]});
            if (bus.out_ready) rcv++;
         end
         if (cyc == 2) begin
            chk("bp.in_ready_stalled", {31'd0, bus.in_ready}, 32'd0);
            chk("bp.accepted_before_stall", sent, 32'd2);
         end
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         if (acc) sent++;
      end
      chk("bp.results_received", rcv, 32'd4);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // Reset mid-stream: both stages full, then rst with a new operand offered.
      @(negedge clk);
      bus.op_a = 32'h3F800000; bus.op_b = 32'h3F800000; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.op_a = 32'h40000000; bus.op_b = 32'h3F800000; bus.sub = 1'b1;
      @(negedge clk);
      chk("rst.pre_out_valid", {31'd0, bus.out_valid}, 32'd1);
      rst = 1'b1;
      bus.op_a = 32'h3FC00000; bus.op_b = 32'h40400000; bus.sub = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst.out_sig", {7'd0, bus.out_sig}, 32'd0);
      chk("rst.out_special", {30'd0, bus.out_special}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rst.drained%0d", k), {31'd0, bus.out_valid}, 32'd0);
      end
      run_vec(1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_add_align.md
# fp_add_align

Two-stage pipelined front end of the single-precision vector FP adder. It accepts two FP32 operands and an add/subtract select, then unpacks, orders, exponent-aligns and adds or subtracts the significands. It delivers sign, exponent and a raw 25-bit significand sum to the leading-one priority-encoder / normalization stage directly downstream. Rounding and packing happen later; this block only supplies a sticky bit for them.

## Interface
- EXP_W, default 8: exponent field width. Only the default is supported and verified.
- MAN_W, default 23: stored mantissa width. The significand is MAN_W+2 = 25 bits.
- clk  input  1  clock. Everything is on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block accepts the pair this cycle.
- op_a  input  32  IEEE-754 single operand A.
- op_b  input  32  IEEE-754 single operand B.
- sub  input  1  1: compute A−B; 0: compute A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sign  output  1  result sign.
- out_exp  output  8  exponent of the larger-magnitude operand, unnormalized.
- out_sig  output  25  magnitude sum. Bit 24 is the carry; bit 23 is the hidden-bit position.
- out_sticky  output  1  OR of all bits of the smaller significand shifted out during alignment.
- out_special  output  2  00 normal, 01 zero, 10 infinity, 11 NaN.

## Operation
- Operand unpack:
  - exp==0 is treated as zero (flush-to-zero for denormals).
  - exp==0xFF with man==0 is infinity; exp==0xFF with man!=0 is NaN.
  - Hidden bit = 1 for normal operands.
- Effective sign of B = op_b[31] ^ sub. eff_sub = sign_A ^ effective sign of B.
- S1 (unpack/order):
  - Compare {exp,man} of A and B. The larger magnitude is "big"; on a tie, A is big.
  - diff = exp_big − exp_small, saturated to 25.
  - Register: big sign, big exp, big 24-bit significand, small 24-bit significand, diff, eff_sub, special class.
- S2 (align/add):
  - aligned = small >> diff. diff ≥ 25 gives aligned = 0.
  - sticky = OR of the bits shifted out.
  - sum = eff_sub ? big − aligned : big + aligned, 25 bits. No underflow is possible because big ≥ aligned.
  - out_sign = big sign, except that an exact-zero sum from effective subtraction gives out_sign = 0.
  - out_exp = big exp.
- Special resolution, in priority order:
  1. Any NaN, or inf − inf under effective subtraction → 11, sign 0.
  2. Any infinity → 10, with the sign of that infinity.
  3. Both operands zero → 01, sign = sign_A & effective sign of B.
  4. Otherwise → 00.
  - When out_special != 00, out_sig = 0 and out_sticky = 0.

## Timing
- Latency is 2 cycles from the accepting edge (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput is 1 operation per cycle.
- Valid/ready is per stage, with v1 and v2 as the stage-valid flags:
  - ready2 = !v2 | out_ready.
  - ready1 = !v1 | ready2.
  - in_ready = ready1. This is a combinational path from out_ready.
- A stage loads when its upstream is valid and the stage itself is ready. Otherwise it holds.
- While out_valid & !out_ready, all out_* are held stable.
- No reordering, loss or duplication of operations. Bubbles collapse.
- Reset:
  - v1 = v2 = 0; out_valid = 0.
  - All out_* data = 0, out_special = 00.
  - in_ready = 1 in the first cycle after reset.
- Reset asserted mid-stream discards both stages. out_valid is 0 on the edge after rst.
- in_valid together with rst in the same cycle: the operation is not accepted.

## Structure
- Shared package fp32_pkg holds:
  - EXP_W, MAN_W, SIG_W = 25, BIAS = 127.
  - EXP_MAX = 8'hFF.
  - The out_special encoding constants: SP_NORM, SP_ZERO, SP_INF, SP_NAN.
- One sub-module, fp_align_shift: a combinational 24-bit right shifter with saturating 5-bit shift and sticky output, instantiated in S2.
- The pipeline registers and handshake stay in fp_add_align.

## Test plan
- 0x3F800000 + 0x3F800000, sub=0 → 2 cycles later: out_sig=0x1000000, out_exp=0x7F, sign 0, sticky 0, special 00.
- 0x3FC00000 − 0x40400000 (1.5 − 3.0) → out_sign=1, out_exp=0x80, out_sig=0x0600000, sticky 0.
- 0x3F800000 + 0x30800000 (diff 30) → out_sig=0x0800000, out_exp=0x7F, sticky 1.
- 0x3F800000 − 0x3F800000 → out_sig=0, out_sign=0, special 00.
- 0x7F800000 − 0x7F800000 → special 11.
- 0xFF800000 + 0x3F800000 → special 10, sign 1.
- Backpressure and reset:
  - Four back-to-back inputs with out_ready=0 for 3 cycles → in_ready drops after 2 accepted; all 4 results emerge in order with held data.
  - rst pulse mid-stream → out_valid=0 on the next edge, then normal operation.
